respondedor_memoria: RTL and testbench
======================================

RESPONDEDOR_MEMORIA -- requirements
Module: respondedor_memoria

Interface
REQ-001 Parameter: RAM_WORDS, default 256, number of 32-bit data RAM words (power of two, at most 256).
REQ-002 Parameter: PRESCALER, default 50000, clk cycles per timer increment (at least 2).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: memWr  input  1  write strobe from the processor, sampled on the rising edge of clk.
REQ-006 Port: direc  input  32  byte address from the processor; direc[1:0] ignored.
REQ-007 Port: datoOut  input  32  write data from the processor.
REQ-008 Port: botones  input  4  raw, asynchronous button levels.
REQ-009 Port: datoIn  output  32  read data to the processor, combinational from direc and current state.

Function
REQ-010 Address map, matched on the full 32-bit direc with [1:0] masked:
- 0x0000_0000 to 0x0000_03FF: RAM, word index direc[9:2] modulo RAM_WORDS.
- 0x0000_1000: BOTONES.
- 0x0000_1004: TIMER_CNT.
- 0x0000_1008: TIMER_CTL.
REQ-011 Unmapped address: datoIn = 0; write ignored, no state change.
REQ-012 Reads have zero-cycle latency: datoIn reflects pre-edge state, so a read and write to the same address in one cycle returns the old value.
REQ-013 RAM write: on the clk edge with memWr=1 and a RAM address, the word is stored; the new value is readable from the next cycle.
REQ-014 Button synchronizer: botones pass through a 2-flop synchronizer per bit, giving sync[3:0].
REQ-015 Press detection: a sync bit going 0->1 sets sticky press[i] on that edge; rising edges are detected against a third registered copy.
REQ-016 BOTONES read value: {24'b0, press[3:0], sync[3:0]}.
REQ-017 BOTONES write clears press[i] where datoOut[4+i]=1 (write-1-to-clear); datoOut[3:0] ignored.
REQ-018 Simultaneous clear and new press on the same bit: set wins, flag stays 1.
REQ-019 Prescaler: internal 0..PRESCALER-1 counter, advancing only while en=1.
- On reaching PRESCALER-1 it returns to 0, TIMER_CNT increments by 1 (wrapping 0xFFFFFFFF->0), and tick sets.
- Holds its value while en=0.
REQ-020 TIMER_CNT read returns the count; a write loads datoOut and clears the prescaler to 0.
REQ-021 Write and increment in the same cycle: the written value wins.
REQ-022 TIMER_CTL read value: {30'b0, tick, en}.
REQ-023 TIMER_CTL write: en <= datoOut[0]; tick cleared if datoOut[1]=1.
REQ-024 Simultaneous tick set and tick clear: set wins.
REQ-025 memWr=0 never alters any state; the synchronizer, prescaler and timer still run.

Reset
REQ-026 rst_n=0 asynchronously clears synchronizer flops, press, prescaler, TIMER_CNT, en and tick to 0; datoIn then shows 0 for all peripheral addresses.
REQ-027 RAM contents are not reset and are undefined until written.
REQ-028 Reset asserted mid-count discards the prescaler phase.
REQ-029 After rst_n deasserts, the first state update occurs on the next clk rising edge.

Verification
REQ-030 RAM: write 0xDEADBEEF to 0x0000_0010, write 0x12345678 to 0x0000_03FC, then read both -> 0xDEADBEEF and 0x12345678; a same-cycle read of 0x10 during a second write returns the old value.
REQ-031 Buttons: raise botones[2] and hold -> BOTONES reads 0x44 exactly 3 cycles later; write 0x40 -> 0x04; release and re-press in the same cycle as a 0x40 clear -> press[2] remains 1.
REQ-032 Timer: PRESCALER=4, write TIMER_CTL=1 -> TIMER_CNT increments every 4 cycles and tick=1 after the first; write TIMER_CTL=0x3 -> tick cleared, en stays 1.
REQ-033 Timer edge cases:
- Load TIMER_CNT=0xFFFFFFFF with en=1 -> wraps to 0 after PRESCALER cycles.
- Write TIMER_CNT=5 on an increment cycle -> reads 5.
- en=0 -> count frozen.
REQ-034 Unmapped: write to 0x0000_2000 then read it -> 0; all other state is unchanged.
REQ-035 Reset: assert rst_n=0 asynchronously mid-count -> TIMER_CNT, TIMER_CTL and BOTONES read 0 immediately, and counting stays stopped after release until en is written.

Source files
------------

// File: rtl/respondedor_memoria.sv
// Memory-mapped responder for a simple processor bus.
// Holds a word-addressed data RAM, a sticky button-press register fed
// through a synchronizer, and a prescaled free-running timer.
//
// Ports:
//   clk      - single clock; all state changes on its rising edge
//   rst_n    - asynchronous active-low reset (RAM contents are not reset)
//   memWr    - write strobe, sampled on the rising edge of clk
//   direc    - byte address; bits [1:0] are ignored
//   datoOut  - write data from the processor
//   botones  - raw asynchronous button levels
//   datoIn   - read data, combinational from direc and the current state
//
// Address map (word aligned):
//   0x0000_0000..0x0000_03FF  RAM, word index direc[9:2] modulo RAM_WORDS
//   0x0000_1000               BOTONES   {24'b0, press[3:0], sync[3:0]}
//   0x0000_1004               TIMER_CNT
//   0x0000_1008               TIMER_CTL {30'b0, tick, en}
//   anything else reads 0 and ignores writes
module respondedor_memoria #(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned PRESCALER = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memWr,
  input  logic [31:0] direc,
  input  logic [31:0] datoOut,
  input  logic [3:0]  botones,
  output logic [31:0] datoIn
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALER - 1);

  localparam logic [31:0] ADDR_BOTONES = 32'h0000_1000;
  localparam logic [31:0] ADDR_CNT     = 32'h0000_1004;
  localparam logic [31:0] ADDR_CTL     = 32'h0000_1008;

  // Address decode on the full word address
  logic [31:0]   word_addr;
  logic          sel_ram, sel_bot, sel_cnt, sel_ctl;
  logic          wr_ram, wr_bot, wr_cnt, wr_ctl;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_lsbs;

  assign word_addr = {direc[31:2], 2'b00};
  assign sel_ram   = (word_addr[31:10] == '0);
  assign sel_bot   = (word_addr == ADDR_BOTONES);
  assign sel_cnt   = (word_addr == ADDR_CNT);
  assign sel_ctl   = (word_addr == ADDR_CTL);
  assign wr_ram    = memWr & sel_ram;
  assign wr_bot    = memWr & sel_bot;
  assign wr_cnt    = memWr & sel_cnt;
  assign wr_ctl    = memWr & sel_ctl;
  assign ram_idx   = direc[AW+1:2];
  assign unused_addr_lsbs = ^direc[1:0];

  // Data RAM: no reset, contents undefined until written
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_idx] <= datoOut;
    end
  end

  // Buttons: two synchronizer stages, a third stage for edge detection
  logic [3:0] sync1, sync2, sync3;
  logic [3:0] press;
  logic [3:0] rise;
  logic [3:0] clr_mask;

  assign rise     = sync2 & ~sync3;
  assign clr_mask = wr_bot ? datoOut[7:4] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      press <= '0;
    end else begin
      sync1 <= botones;
      sync2 <= sync1;
      sync3 <= sync2;
      // a new press on the same edge as a clear keeps the flag set
      press <= (press & ~clr_mask) | rise;
    end
  end

  // Timer: prescaler advances only while enabled
  logic [PW-1:0] pre;
  logic [31:0]   cnt;
  logic          en;
  logic          tick;
  logic          wrap;

  assign wrap = en && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      cnt  <= '0;
      en   <= 1'b0;
      tick <= 1'b0;
    end else begin
      if (wr_cnt) begin
        // a load overrides a coinciding increment and restarts the phase
        cnt <= datoOut;
        pre <= '0;
      end else if (en) begin
        if (wrap) begin
          pre <= '0;
          cnt <= cnt + 32'd1;
        end else begin
          pre <= pre + PW'(1);
        end
      end

      if (wr_ctl) begin
        en <= datoOut[0];
      end

      if (wrap) begin
        tick <= 1'b1;
      end else if (wr_ctl && datoOut[1]) begin
        tick <= 1'b0;
      end
    end
  end

  // Zero-latency read mux
  always_comb begin
    datoIn = '0;
    if (sel_ram) begin
      datoIn = ram[ram_idx];
    end else if (sel_bot) begin
      datoIn = {24'b0, press, sync2};
    end else if (sel_cnt) begin
      datoIn = cnt;
    end else if (sel_ctl) begin
      datoIn = {30'b0, tick, en};
    end
  end

endmodule

// File: tb/tb_respondedor_memoria.sv
module tb_respondedor_memoria;

  localparam int PRE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memWr;
  logic [31:0] direc;
  logic [31:0] datoOut;
  logic [3:0]  botones;
  logic [31:0] datoIn;

  int passed = 0;
  int total  = 0;

  respondedor_memoria #(.RAM_WORDS(256), .PRESCALER(PRE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .memWr  (memWr),
    .direc  (direc),
    .datoOut(datoOut),
    .botones(botones),
    .datoIn (datoIn)
  );

  always #5 clk = ~clk;

  // Reference model, abstract state
  bit [31:0] m_ram   [256];
  bit        m_valid [256];
  bit [3:0]  m_hist  [3];   // botones seen at the last three edges, newest first
  bit [3:0]  m_press;
  int        m_phase;       // enabled cycles since the last timer step/reload
  bit [31:0] m_cnt;
  bit        m_en, m_tick;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_press = '0;
    m_phase = 0;
    m_cnt   = '0;
    m_en    = 1'b0;
    m_tick  = 1'b0;
  endtask

  task automatic model_update();
    logic [31:0] w;
    logic [3:0]  newly;
    bit          step;
    w     = {direc[31:2], 2'b00};
    newly = m_hist[1] & ~m_hist[2];
    step  = m_en && (m_phase == PRE - 1);
    if (memWr && w == 32'h1000) m_press = m_press & ~datoOut[7:4];
    m_press = m_press | newly;
    if (m_en) begin
      if (step) begin
        m_phase = 0;
        m_cnt   = m_cnt + 1;
      end else begin
        m_phase = m_phase + 1;
      end
    end
    if (memWr && w == 32'h1004) begin
      m_cnt   = datoOut;
      m_phase = 0;
    end
    if (memWr && w == 32'h1008) begin
      if (datoOut[1]) m_tick = 1'b0;
      m_en = datoOut[0];
    end
    if (step) m_tick = 1'b1;
    if (memWr && w < 32'h400) begin
      m_ram[w[9:2]]   = datoOut;
      m_valid[w[9:2]] = 1'b1;
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = botones;
  endtask

  // returns 0 in ok when the expected value is undefined (unwritten RAM)
  function automatic logic [31:0] model_read(input logic [31:0] a, output bit ok);
    logic [31:0] w;
    w  = {a[31:2], 2'b00};
    ok = 1'b1;
    if (w < 32'h400) begin
      ok = m_valid[w[9:2]];
      return m_ram[w[9:2]];
    end
    if (w == 32'h1000) return {24'b0, m_press, m_hist[1]};
    if (w == 32'h1004) return m_cnt;
    if (w == 32'h1008) return {30'b0, m_tick, m_en};
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memWr = 1'b1; direc = a; datoOut = d;
    step();
    memWr = 1'b0; datoOut = '0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    memWr = 1'b0; direc = a;
    #1;
    check(name, datoIn, exp);
  endtask

  task automatic mdl_check(input string name, input logic [31:0] a);
    logic [31:0] e;
    bit ok;
    memWr = 1'b0; direc = a;
    #1;
    e = model_read(a, ok);
    if (ok) check(name, datoIn, e);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    rst_n = 1'b0; memWr = 1'b0; direc = '0; datoOut = '0; botones = '0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    model_reset();
    #12;
    rd_check("rst_botones", 32'h1000, 32'h0);
    rd_check("rst_cnt",     32'h1004, 32'h0);
    rd_check("rst_ctl",     32'h1008, 32'h0);
    rst_n = 1'b1;

    // Bus vectors: expected value is the pre-edge read of the same address
    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'h1234_5678};
    tbl[4]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF};
    tbl[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hCAFE_F00D};
    tbl[6]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hCAFE_F00D};
    tbl[7]  = '{1'b1, 32'h4000_0010, 32'h1111_1111, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hCAFE_F00D};
    tbl[9]  = '{1'b1, 32'h0000_2000, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h0};
    tbl[11] = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
    tbl[12] = '{1'b0, 32'h0000_1008, 32'h0,         1'b1, 32'h0};
    tbl[13] = '{1'b0, 32'h0000_1004, 32'h0,         1'b1, 32'h0};
    tbl[14] = '{1'b0, 32'h0001_1000, 32'h0,         1'b1, 32'h0};
    tbl[15] = '{1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'h1234_5678};
    for (int i = 0; i < 16; i++) begin
      memWr = tbl[i].wr; direc = tbl[i].addr; datoOut = tbl[i].data;
      #1;
      if (tbl[i].chk) check($sformatf("vec%0d", i), datoIn, tbl[i].exp);
      step();
    end
    memWr = 1'b0;

    // Buttons: press visible three edges after the raise
    botones = 4'b0100;
    rd_check("btn_e0", 32'h1000, 32'h00);
    step();
    rd_check("btn_e1", 32'h1000, 32'h00);
    step();
    rd_check("btn_e2", 32'h1000, 32'h04);
    step();
    rd_check("btn_e3", 32'h1000, 32'h44);
    wr(32'h1000, 32'h0000_004F);
    rd_check("btn_clr", 32'h1000, 32'h04);
    botones = 4'b0000;
    step();
    botones = 4'b0100;
    step();
    rd_check("btn_released", 32'h1000, 32'h00);
    step();
    wr(32'h1000, 32'h40);   // clear on the same edge the new press lands
    rd_check("btn_set_wins", 32'h1000, 32'h44);
    mdl_check("btn_model", 32'h1000);

    // Timer basic counting
    wr(32'h1008, 32'h1);
    rd_check("tmr_c0", 32'h1004, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step();
      rd_check($sformatf("tmr_c%0d", i), 32'h1004, 32'(i / PRE));
    end
    rd_check("tmr_tick", 32'h1008, 32'h3);
    wr(32'h1008, 32'h3);
    rd_check("tmr_tick_clr", 32'h1008, 32'h1);
    rd_check("tmr_cnt_after", 32'h1004, 32'h2);

    // Wrap from all ones, load on an increment edge, freeze
    wr(32'h1004, 32'hFFFF_FFFF);
    for (int i = 1; i < PRE; i++) step();
    rd_check("wrap_before", 32'h1004, 32'hFFFF_FFFF);
    step();
    rd_check("wrap_after", 32'h1004, 32'h0);
    for (int i = 1; i < PRE; i++) step();
    wr(32'h1004, 32'h5);
    rd_check("load_wins", 32'h1004, 32'h5);
    wr(32'h1008, 32'h0);
    for (int i = 0; i < 10; i++) step();
    rd_check("frozen_cnt", 32'h1004, 32'h5);
    rd_check("frozen_ctl", 32'h1008, 32'h2);

    // Unmapped write leaves everything alone
    wr(32'h0000_0000, 32'h0BAD_F00D);
    wr(32'h0000_2000, 32'hFFFF_FFFF);
    rd_check("unmap_rd", 32'h2000, 32'h0);
    rd_check("unmap_ram0", 32'h0000, 32'h0BAD_F00D);
    rd_check("unmap_cnt", 32'h1004, 32'h5);
    mdl_check("unmap_bot", 32'h1000);
    mdl_check("unmap_ctl", 32'h1008);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 2: direc = {22'b0, 8'($urandom), 2'($urandom)};
        3:       direc = 32'h1000;
        4:       direc = 32'h1004;
        5:       direc = 32'h1008;
        6: begin
          case ($urandom_range(0, 3))
            0:       direc = 32'h0000_2000;
            1:       direc = 32'h0000_100C;
            2:       direc = 32'h8000_0010;
            default: direc = $urandom | 32'h0001_0000;
          endcase
        end
        default: direc = {28'b0, 2'($urandom), 2'b00};
      endcase
      memWr = ($urandom_range(0, 2) == 0);
      if (r == 5) datoOut = 32'($urandom_range(0, 3)) | 32'h1;
      else if (r == 4 && $urandom_range(0, 3) == 0) datoOut = 32'hFFFF_FFFE;
      else datoOut = $urandom;
      if (r == 5 && $urandom_range(0, 4) == 0) datoOut = 32'h2;
      if ($urandom_range(0, 3) == 0) botones = 4'($urandom);
      #1;
      begin
        logic [31:0] e;
        bit ok;
        e = model_read(direc, ok);
        if (ok) check($sformatf("rand%0d@%h", n, direc), datoIn, e);
      end
      step();
    end
    memWr = 1'b0;

    // Asynchronous reset in the middle of a count
    botones = 4'b0000;
    wr(32'h1008, 32'h1);
    for (int i = 0; i < 6; i++) step();
    #3;
    rst_n = 1'b0;
    model_reset();
    rd_check("arst_cnt", 32'h1004, 32'h0);
    rd_check("arst_ctl", 32'h1008, 32'h0);
    rd_check("arst_bot", 32'h1000, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rd_check("post_rst_cnt", 32'h1004, 32'h0);
    rd_check("post_rst_ctl", 32'h1008, 32'h0);
    mdl_check("post_rst_bot", 32'h1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
